instruction_fetch: RTL and testbench

- Fetches 16-bit instructions from instruction memory and presents them, decoded into fields, to the control unit and register file.
- Drives the 4-bit OPCODE consumed by the control unit.
- Owns the program counter and applies taken-branch redirects reported back by the datapath.
- Holds one instruction register plus a one-entry prefetch buffer, so memory latency overlaps execution stalls.

---
 rtl/instruction_fetch_pkg.sv | 31 +++
 rtl/instruction_fetch_fetch_buffer.sv | 97 +++++++++
 rtl/instruction_fetch.sv | 117 +++++++++++
 tb/tb_instruction_fetch.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions: instruction word type, field positions and opcodes.
// Imported by the fetch unit and by the control unit that consumes OPCODE.
package instruction_fetch_pkg;

   typedef logic [15:0] instr_t;

   localparam int OPCODE_HI = 15;
   localparam int OPCODE_LO = 12;
   localparam int RS_HI     = 11;
   localparam int RS_LO     = 10;
   localparam int RT_HI     = 9;
   localparam int RT_LO     = 8;
   localparam int RD_HI     = 7;
   localparam int RD_LO     = 6;
   localparam int FUNCT_HI  = 5;
   localparam int FUNCT_LO  = 0;
   localparam int IMM_HI    = 7;
   localparam int IMM_LO    = 0;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ADDI  = 4'b0100;
   localparam logic [3:0] OP_LW    = 4'b1100;
   localparam logic [3:0] OP_SW    = 4'b1101;
   localparam logic [3:0] OP_JMP   = 4'b1110;
   localparam logic [3:0] OP_BEQ   = 4'b1111;

   function automatic logic [7:0] imm_of(input instr_t instr);
      return instr[IMM_HI:IMM_LO];
   endfunction

endpackage

// File: rtl/instruction_fetch_fetch_buffer.sv
// Two-entry skid queue: instruction register (IR) in front of a one-entry
// prefetch buffer (PB). Flush empties both entries and drops a same-cycle push.
module fetch_buffer
   import instruction_fetch_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            push,
   input  instr_t          push_instr,
   input  logic [PC_W-1:0] push_pc,
   input  logic            pop,
   output logic            ir_valid,
   output instr_t          ir_instr,
   output logic [PC_W-1:0] ir_pc,
   output logic            pb_valid
);

   logic            ir_valid_reg, ir_valid_next;
   instr_t          ir_instr_reg, ir_instr_next;
   logic [PC_W-1:0] ir_pc_reg, ir_pc_next;
   logic            pb_valid_reg, pb_valid_next;
   instr_t          pb_instr_reg, pb_instr_next;
   logic [PC_W-1:0] pb_pc_reg, pb_pc_next;

   always_comb begin
      ir_valid_next = ir_valid_reg;
      ir_instr_next = ir_instr_reg;
      ir_pc_next    = ir_pc_reg;
      pb_valid_next = pb_valid_reg;
      pb_instr_next = pb_instr_reg;
      pb_pc_next    = pb_pc_reg;
      if (flush) begin
         ir_valid_next = 1'b0;
         pb_valid_next = 1'b0;
      end else if (pop) begin
         if (pb_valid_reg) begin
            ir_valid_next = 1'b1;
            ir_instr_next = pb_instr_reg;
            ir_pc_next    = pb_pc_reg;
            pb_valid_next = push;
            pb_instr_next = push_instr;
            pb_pc_next    = push_pc;
         end else if (push) begin
            // response lands straight in IR: no bubble behind the consumed word
            ir_valid_next = 1'b1;
            ir_instr_next = push_instr;
            ir_pc_next    = push_pc;
         end else begin
            ir_valid_next = 1'b0;
         end
      end else if (push) begin
         if (!ir_valid_reg) begin
            ir_valid_next = 1'b1;
            ir_instr_next = push_instr;
            ir_pc_next    = push_pc;
         end else begin
            pb_valid_next = 1'b1;
            pb_instr_next = push_instr;
            pb_pc_next    = push_pc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ir_valid_reg <= 1'b0;
         ir_instr_reg <= '0;
         ir_pc_reg    <= '0;
         pb_valid_reg <= 1'b0;
         pb_instr_reg <= '0;
         pb_pc_reg    <= '0;
      end else begin
         ir_valid_reg <= ir_valid_next;
         ir_instr_reg <= ir_instr_next;
         ir_pc_reg    <= ir_pc_next;
         pb_valid_reg <= pb_valid_next;
         pb_instr_reg <= pb_instr_next;
         pb_pc_reg    <= pb_pc_next;
      end
   end

   // Fetch is paused while PB holds a word, so a push can never meet a full PB.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         assert (!pb_valid_reg);
      end
   end

   assign ir_valid = ir_valid_reg;
   assign ir_instr = ir_instr_reg;
   assign ir_pc    = ir_pc_reg;
   assign pb_valid = pb_valid_reg;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the fetch PC, keeps one memory read in flight,
// applies taken-branch redirects and presents the decoded IR to the core.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            IMEM_REQ,
   output logic [PC_W-1:0] IMEM_ADDR,
   input  logic            IMEM_VALID,
   input  logic [15:0]     IMEM_DATA,
   output logic            INSTR_VALID,
   input  logic            INSTR_READY,
   output logic [3:0]      OPCODE,
   output logic [1:0]      RS,
   output logic [1:0]      RT,
   output logic [1:0]      RD,
   output logic [5:0]      FUNCT,
   output logic [7:0]      IMM,
   output logic [PC_W-1:0] ISSUE_PC,
   input  logic            BR_TAKEN
);

   logic [PC_W-1:0] fpc_reg, fpc_next;
   logic [PC_W-1:0] pend_pc_reg, pend_pc_next;
   logic            out_reg, out_next;
   logic            disc_reg, disc_next;

   logic            ir_valid;
   logic            pb_valid;
   instr_t          ir_instr;
   logic [PC_W-1:0] ir_pc;

   logic            fire;
   logic            redirect;
   logic            push;
   logic [PC_W-1:0] imm_ext;
   logic [PC_W-1:0] branch_target;

   assign fire     = ir_valid & INSTR_READY;
   assign redirect = fire & BR_TAKEN;

   // A request is held back while a discarded read is still due, so the memory
   // never sees two reads in flight; on a redirect the request waits for the target.
   assign IMEM_REQ  = rst_n & ~out_reg & ~disc_reg & ~pb_valid & ~redirect;
   assign IMEM_ADDR = IMEM_REQ ? fpc_reg : '0;

   assign push = IMEM_VALID & ~disc_reg & ~redirect;

   assign imm_ext       = PC_W'($signed(imm_of(ir_instr)));
   assign branch_target = ir_pc + PC_W'(1) + imm_ext;

   always_comb begin
      fpc_next     = fpc_reg;
      pend_pc_next = pend_pc_reg;
      out_next     = out_reg;
      disc_next    = disc_reg;
      if (IMEM_VALID) begin
         out_next  = 1'b0;
         disc_next = 1'b0;
      end else if (redirect && out_reg) begin
         disc_next = 1'b1;
      end
      if (IMEM_REQ) begin
         out_next     = 1'b1;
         fpc_next     = fpc_reg + PC_W'(1);
         pend_pc_next = fpc_reg;
      end
      if (redirect) begin
         fpc_next = branch_target;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fpc_reg     <= RESET_PC;
         pend_pc_reg <= '0;
         out_reg     <= 1'b0;
         // a read still in flight across reset must be dropped when it returns
         disc_reg    <= (out_reg | disc_reg) & ~IMEM_VALID;
      end else begin
         fpc_reg     <= fpc_next;
         pend_pc_reg <= pend_pc_next;
         out_reg     <= out_next;
         disc_reg    <= disc_next;
      end
   end

   fetch_buffer #(
      .PC_W (PC_W)
   ) u_fetch_buffer (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect),
      .push       (push),
      .push_instr (IMEM_DATA),
      .push_pc    (pend_pc_reg),
      .pop        (fire),
      .ir_valid   (ir_valid),
      .ir_instr   (ir_instr),
      .ir_pc      (ir_pc),
      .pb_valid   (pb_valid)
   );

   assign INSTR_VALID = ir_valid;
   assign OPCODE      = ir_instr[OPCODE_HI:OPCODE_LO];
   assign RS          = ir_instr[RS_HI:RS_LO];
   assign RT          = ir_instr[RT_HI:RT_LO];
   assign RD          = ir_instr[RD_HI:RD_LO];
   assign FUNCT       = ir_instr[FUNCT_HI:FUNCT_LO];
   assign IMM         = ir_instr[IMM_HI:IMM_LO];
   assign ISSUE_PC    = ir_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, multi-cycle corner
// sequences and a randomized run checked against a program-order model.
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   localparam int              PC_W     = 8;
   localparam logic [PC_W-1:0] RESET_PC = 8'h00;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            IMEM_REQ;
   logic [PC_W-1:0] IMEM_ADDR;
   logic            IMEM_VALID = 1'b0;
   logic [15:0]     IMEM_DATA = 16'h0;
   logic            INSTR_VALID;
   logic            INSTR_READY = 1'b0;
   logic [3:0]      OPCODE;
   logic [1:0]      RS, RT, RD;
   logic [5:0]      FUNCT;
   logic [7:0]      IMM;
   logic [PC_W-1:0] ISSUE_PC;
   logic            BR_TAKEN = 1'b0;

   always #5 clk = ~clk;

   instruction_fetch #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .IMEM_REQ    (IMEM_REQ),
      .IMEM_ADDR   (IMEM_ADDR),
      .IMEM_VALID  (IMEM_VALID),
      .IMEM_DATA   (IMEM_DATA),
      .INSTR_VALID (INSTR_VALID),
      .INSTR_READY (INSTR_READY),
      .OPCODE      (OPCODE),
      .RS          (RS),
      .RT          (RT),
      .RD          (RD),
      .FUNCT       (FUNCT),
      .IMM         (IMM),
      .ISSUE_PC    (ISSUE_PC),
      .BR_TAKEN    (BR_TAKEN)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int lat_fixed = 1;
   int fires = 0;
   int req_count = 0;

   logic [15:0] ram [256];
   int          due_q[$];
   logic [15:0] data_q[$];

   logic [PC_W-1:0] exp_pc = RESET_PC;
   bit              prev_stall = 1'b0;
   logic [PC_W-1:0] prev_pc = '0;
   logic [15:0]     prev_word = '0;

   typedef struct {
      bit         ready;
      bit         exp_req;
      logic [7:0] exp_addr;
      bit         exp_valid;
      logic [7:0] exp_pc;
      logic [3:0] exp_op;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Rising edge plus settle time; memory answers in the cycle it is due.
   task automatic edge_in();
      @(posedge clk);
      #1;
      cyc++;
      IMEM_VALID = 1'b0;
      IMEM_DATA  = 16'($urandom);
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         IMEM_VALID = 1'b1;
         IMEM_DATA  = data_q[0];
         void'(due_q.pop_front());
         void'(data_q.pop_front());
      end
   endtask

   // Falling edge: record requests, run the program-order model and stall check.
   task automatic settle();
      int          lat;
      int          due;
      int          sx;
      logic [15:0] w;
      logic [15:0] cur;
      @(negedge clk);
      cur = {OPCODE, RS, RT, RD, FUNCT};
      if (IMEM_REQ) begin
         req_count++;
         chk("one_outstanding", due_q.size(), 0);
         lat = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 4);
         due = cyc + lat;
         if (due_q.size() > 0 && due <= due_q[$]) due = due_q[$] + 1;
         due_q.push_back(due);
         data_q.push_back(ram[IMEM_ADDR]);
      end
      if (prev_stall) begin
         chk("stall_valid", INSTR_VALID, 1);
         chk("stall_pc", ISSUE_PC, prev_pc);
         chk("stall_word", cur, prev_word);
      end
      if (!rst_n) begin
         exp_pc = RESET_PC;
      end else if (INSTR_VALID && INSTR_READY) begin
         fires++;
         w = ram[exp_pc];
         chk("fire_pc", ISSUE_PC, exp_pc);
         chk("fire_word", cur, w);
         chk("fire_imm", IMM, w[7:0]);
         if (BR_TAKEN) begin
            sx = int'($signed(w[7:0]));
            exp_pc = PC_W'(int'(exp_pc) + 1 + sx);
         end else begin
            exp_pc = exp_pc + 8'd1;
         end
      end
      prev_stall = rst_n && INSTR_VALID && !INSTR_READY;
      prev_pc    = ISSUE_PC;
      prev_word  = cur;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         edge_in();
         rst_n = 1'b0;
         INSTR_READY = 1'b0;
         BR_TAKEN = 1'b0;
         settle();
         chk("rst_req", IMEM_REQ, 0);
         chk("rst_addr", IMEM_ADDR, 0);
         if (i > 0) begin
            chk("rst_valid", INSTR_VALID, 0);
            chk("rst_opcode", OPCODE, 0);
            chk("rst_issue_pc", ISSUE_PC, 0);
         end
      end
   endtask

   task automatic load_base_prog();
      for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
      ram[0] = 16'h1123;
      ram[1] = 16'h9205;
      ram[2] = 16'hC304;
      ram[3] = 16'hD105;
   endtask

   initial begin
      int first_req;
      int first_pc;
      int got_pc;
      int r0;
      bit found;
      bit saw_fe;

      tbl[0] = '{1, 1, 8'd0, 0, 8'd0, 4'h0};
      tbl[1] = '{1, 0, 8'd0, 0, 8'd0, 4'h0};
      tbl[2] = '{1, 1, 8'd1, 1, 8'd0, 4'h1};
      tbl[3] = '{1, 0, 8'd0, 0, 8'd0, 4'h0};
      tbl[4] = '{1, 1, 8'd2, 1, 8'd1, 4'h9};
      tbl[5] = '{1, 0, 8'd0, 0, 8'd0, 4'h0};
      tbl[6] = '{1, 1, 8'd3, 1, 8'd2, 4'hC};
      tbl[7] = '{1, 0, 8'd0, 0, 8'd0, 4'h0};
      tbl[8] = '{1, 1, 8'd4, 1, 8'd3, 4'hD};
      tbl[9] = '{1, 0, 8'd0, 0, 8'd0, 4'h0};

      // sequential fetch, 1-cycle memory, consumer always ready
      load_base_prog();
      lat_fixed = 1;
      do_reset(5);
      for (int i = 0; i < 10; i++) begin
         edge_in();
         rst_n = 1'b1;
         INSTR_READY = tbl[i].ready;
         BR_TAKEN = 1'b0;
         settle();
         chk($sformatf("t1_req[%0d]", i), IMEM_REQ, tbl[i].exp_req);
         if (tbl[i].exp_req) chk($sformatf("t1_addr[%0d]", i), IMEM_ADDR, tbl[i].exp_addr);
         chk($sformatf("t1_valid[%0d]", i), INSTR_VALID, tbl[i].exp_valid);
         if (tbl[i].exp_valid) begin
            chk($sformatf("t1_pc[%0d]", i), ISSUE_PC, tbl[i].exp_pc);
            chk($sformatf("t1_op[%0d]", i), OPCODE, tbl[i].exp_op);
         end
         if (i == 4) begin
            chk("t1_rs", RS, 0);
            chk("t1_rt", RT, 2);
            chk("t1_imm", IMM, 8'h05);
         end
      end

      // consumer stalled: IR and PB fill, fetch pauses, resumes after drain
      do_reset(5);
      r0 = req_count;
      for (int i = 0; i < 10; i++) begin
         edge_in();
         rst_n = 1'b1;
         INSTR_READY = 1'b0;
         settle();
         if (INSTR_VALID) chk("t2_hold_pc", ISSUE_PC, 0);
      end
      chk("t2_req_count", req_count - r0, 2);
      chk("t2_valid_held", INSTR_VALID, 1);
      edge_in();
      INSTR_READY = 1'b1;
      settle();
      chk("t2_req_blocked", IMEM_REQ, 0);
      edge_in();
      settle();
      chk("t2_valid_next", INSTR_VALID, 1);
      chk("t2_pc_next", ISSUE_PC, 1);
      chk("t2_resume_req", IMEM_REQ, 1);
      chk("t2_resume_addr", IMEM_ADDR, 2);

      // backward beq at 4 with a prefetch of 5 in flight, 3-cycle memory
      load_base_prog();
      ram[4] = 16'hF0FC;
      ram[5] = 16'h5A5A;
      lat_fixed = 3;
      do_reset(5);
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         edge_in();
         rst_n = 1'b1;
         BR_TAKEN = 1'b0;
         if (INSTR_VALID && ISSUE_PC == 8'd4) begin
            found = 1'b1;
            INSTR_READY = 1'b0;
         end else begin
            INSTR_READY = 1'b1;
         end
         settle();
      end
      chk("t3_beq_reached", found, 1);
      chk("t3_prefetch5_req", IMEM_REQ, 1);
      chk("t3_prefetch5_addr", IMEM_ADDR, 5);
      edge_in();
      INSTR_READY = 1'b1;
      BR_TAKEN = 1'b1;
      settle();
      chk("t3_branch_no_req", IMEM_REQ, 0);
      first_req = -1;
      first_pc = -1;
      for (int i = 0; i < 40 && first_pc < 0; i++) begin
         edge_in();
         INSTR_READY = 1'b1;
         BR_TAKEN = 1'b0;
         settle();
         if (IMEM_REQ && first_req < 0) first_req = int'(IMEM_ADDR);
         if (INSTR_VALID && first_pc < 0) first_pc = int'(ISSUE_PC);
      end
      chk("t3_next_addr", first_req, 1);
      chk("t3_next_pc", first_pc, 1);

      // forward branch from 0xFE with IMM=1 wraps to 0
      load_base_prog();
      ram[0] = 16'hF0FD;
      ram[8'hFE] = 16'hF001;
      lat_fixed = 1;
      do_reset(5);
      saw_fe = 1'b0;
      got_pc = -1;
      for (int i = 0; i < 60 && got_pc < 0; i++) begin
         edge_in();
         rst_n = 1'b1;
         INSTR_READY = 1'b1;
         BR_TAKEN = INSTR_VALID && (OPCODE == OP_BEQ);
         settle();
         if (INSTR_VALID && INSTR_READY) begin
            if (saw_fe && got_pc < 0) got_pc = int'(ISSUE_PC);
            if (ISSUE_PC == 8'hFE) saw_fe = 1'b1;
         end
      end
      chk("t4_saw_fe", saw_fe, 1);
      chk("t4_wrap_pc", got_pc, 0);

      // one-cycle reset with a read in flight; the late word must be dropped
      load_base_prog();
      ram[0] = 16'h1111;
      lat_fixed = 3;
      do_reset(5);
      edge_in();
      rst_n = 1'b1;
      INSTR_READY = 1'b1;
      settle();
      chk("t5_first_req", IMEM_REQ, 1);
      ram[0] = 16'h2222;
      edge_in();
      rst_n = 1'b0;
      settle();
      first_pc = -1;
      for (int i = 0; i < 40 && first_pc < 0; i++) begin
         edge_in();
         rst_n = 1'b1;
         INSTR_READY = 1'b1;
         settle();
         if (INSTR_VALID) begin
            first_pc = int'(ISSUE_PC);
            chk("t5_first_op", OPCODE, 4'h2);
         end
      end
      chk("t5_first_pc", first_pc, 0);

      // BR_TAKEN while stalled is ignored
      load_base_prog();
      ram[0] = 16'hF010;
      lat_fixed = 1;
      do_reset(5);
      got_pc = -1;
      for (int i = 0; i < 30 && got_pc < 0; i++) begin
         edge_in();
         rst_n = 1'b1;
         INSTR_READY = (i >= 8);
         BR_TAKEN = (i < 8);
         settle();
         if (i >= 8 && INSTR_VALID && ISSUE_PC != 8'd0) got_pc = int'(ISSUE_PC);
      end
      chk("t6_no_redirect", got_pc, 1);

      // randomized program, latency, stalls, branches and occasional resets
      for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
      lat_fixed = 0;
      do_reset(5);
      r0 = fires;
      for (int i = 0; i < 4000; i++) begin
         edge_in();
         rst_n = ($urandom_range(0, 299) != 0);
         INSTR_READY = ($urandom_range(0, 9) < 7);
         BR_TAKEN = ($urandom_range(0, 3) == 0);
         settle();
      end
      chk("rand_progress", (fires - r0) > 300, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
